muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the EX stage. The main ALU stays single-cycle. When the decoder flags an M-extension R-type instruction (ALUOp = 10, Funct7 = 0000001), this block takes the operands, runs a 32-step shift-add multiply or restoring divide, and holds the pipeline stalled until the result is ready. It owns the stall request for M-ops and is aborted by pipeline flushes.

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_if
// Purpose  : Handshake/data bundle between the EX stage and the iterative
//            RV32M multiply/divide sequencer.
// Ports    : master (EX stage) drives start, Funct3, SrcA, SrcB, flush and
//            observes busy, stall, done, result; slave (sequencer) is the
//            mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        Funct3;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              flush;
    logic              busy;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output start, Funct3, SrcA, SrcB, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB, flush,
        output busy, stall, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide unit in the EX stage. Shift-add
//            multiply or restoring divide, one bit per cycle over DATA_W
//            cycles, holding the pipeline stalled until the result is ready.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous active-high reset
//            bus    - slave side of muldiv_sequencer_if (start/Funct3/SrcA/
//                     SrcB/flush in; busy/stall/done/result out)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    muldiv_sequencer_if.slave     bus
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_PREP = 3'd1;
    localparam logic [2:0] C_CALC = 3'd2;
    localparam logic [2:0] C_FIX  = 3'd3;
    localparam logic [2:0] C_DONE = 3'd4;

    localparam logic [CNT_W-1:0]  C_LAST    = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] C_ONES    = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] C_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [2:0]          r_op;
    // Raw operands after latching; from PREP on they hold the magnitudes and
    // are shifted left in CALC (multiplier in r_b, dividend in r_a).
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_neg_q;    // product / quotient sign
    logic                r_neg_r;    // remainder sign
    logic [CNT_W-1:0]    r_count;
    logic [2*DATA_W-1:0] r_acc;      // product, or {remainder, quotient}
    logic [DATA_W-1:0]   r_result;

    logic                w_accept;
    logic                w_busy;
    logic                w_stall;
    logic                w_done;

    assign w_accept = (r_state == C_IDLE) && bus.start && !bus.flush;

    // ---------------- operand preparation ----------------
    logic                w_is_div;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [DATA_W-1:0]   w_special_res;

    assign w_is_div   = r_op[2];
    // Divides: even encodings are signed. Multiplies: A unsigned only for
    // MULHU, B unsigned for MULHSU and MULHU.
    assign w_sgn_a    = w_is_div ? !r_op[0] : (r_op[1:0] != 2'b11);
    assign w_sgn_b    = w_is_div ? !r_op[0] : !r_op[1];
    assign w_neg_a    = w_sgn_a && r_a[DATA_W-1];
    assign w_neg_b    = w_sgn_b && r_b[DATA_W-1];
    assign w_mag_a    = w_neg_a ? -r_a : r_a;
    assign w_mag_b    = w_neg_b ? -r_b : r_b;
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_ovf      = w_is_div && !r_op[0] && (r_a == C_MOST_NEG) && (r_b == C_ONES);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = r_op[1] ? r_a : C_ONES;
        end else begin
            w_special_res = r_op[1] ? '0 : C_MOST_NEG;
        end
    end

    // ---------------- one iteration ----------------
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_partial;
    logic [DATA_W-1:0]   w_diff;
    logic                w_fits;

    assign w_mul_next = {r_acc[2*DATA_W-2:0], 1'b0} +
                        (r_b[DATA_W-1] ? {{DATA_W{1'b0}}, r_a} : '0);

    // Shifted remainder can reach DATA_W+1 bits; when it fits the divisor the
    // difference always fits back into DATA_W bits.
    assign w_partial = {r_acc[2*DATA_W-1:DATA_W], r_a[DATA_W-1]};
    assign w_fits    = (w_partial >= {1'b0, r_b});
    assign w_diff    = w_partial[DATA_W-1:0] - r_b;

    // ---------------- sign fix-up and field select ----------------
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fix_res;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = C_IDLE;
        end else begin
            case (r_state)
                C_IDLE:  w_next = w_accept ? C_PREP : C_IDLE;
                C_PREP:  w_next = w_special ? C_DONE : C_CALC;
                C_CALC:  w_next = (r_count == C_LAST) ? C_FIX : C_CALC;
                C_FIX:   w_next = C_DONE;
                C_DONE:  w_next = C_IDLE;
                default: w_next = C_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy  = (r_state != C_IDLE);
        // Combinational so the hazard unit sees the stall in the accept cycle.
        w_stall = w_accept || (r_state == C_PREP) || (r_state == C_CALC) ||
                  (r_state == C_FIX);
        w_done  = (r_state == C_DONE);
    end

    assign bus.busy   = w_busy;
    assign bus.stall  = w_stall;
    assign bus.done   = w_done;
    assign bus.result = r_result;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_op <= bus.Funct3;
                        r_a  <= bus.SrcA;
                        r_b  <= bus.SrcB;
                    end
                end
                C_PREP: begin
                    r_a     <= w_mag_a;
                    r_b     <= w_mag_b;
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                    r_count <= '0;
                    r_acc   <= '0;
                    if (w_special && !bus.flush) begin
                        r_result <= w_special_res;
                    end
                end
                C_CALC: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_is_div) begin
                        r_acc[2*DATA_W-1:DATA_W] <= w_fits ? w_diff : w_partial[DATA_W-1:0];
                        r_acc[DATA_W-1:0]        <= {r_acc[DATA_W-2:0], w_fits};
                        r_a                      <= {r_a[DATA_W-2:0], 1'b0};
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= {r_b[DATA_W-2:0], 1'b0};
                    end
                end
                C_FIX: begin
                    if (!bus.flush) begin
                        r_result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. A cycle-timeline model
//            computes results with plain 64-bit arithmetic and is compared
//            against busy/stall/done/result on every cycle; directed
//            operations pin literal results and latencies.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int DATA_W = 32;
    localparam int LAT    = DATA_W + 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_sequencer_if #(.DATA_W(DATA_W)) mif ();

    muldiv_sequencer #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic [63:0] ua64;
        logic [63:0] ub64;
        int          ia;
        int          ib;
        logic        ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        ia   = a;
        ib   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = ua64 * ub64;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return LAT;
    endfunction

    // ---------------- timeline model ----------------
    // m_cyc counts cycles since acceptance; the done cycle is m_cyc == m_lat.
    logic        m_ok;
    logic        m_active;
    int          m_cyc;
    int          m_lat;
    logic [31:0] m_exp;
    logic [31:0] m_result;

    initial begin
        m_ok     = 1'b0;
        m_active = 1'b0;
        m_cyc    = 0;
        m_lat    = LAT;
        m_exp    = '0;
        m_result = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_cyc    = 0;
            m_result = '0;
            m_ok     = 1'b1;
        end else if (mif.flush) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_cyc == m_lat) begin
                m_active = 1'b0;
            end else begin
                m_cyc = m_cyc + 1;
                if (m_cyc == m_lat) m_result = m_exp;
            end
        end else if (mif.start) begin
            m_active = 1'b1;
            m_cyc    = 1;
            m_exp    = ref_calc(mif.Funct3, mif.SrcA, mif.SrcB);
            m_lat    = ref_lat(mif.Funct3, mif.SrcA, mif.SrcB);
        end
    end

    always @(negedge clk) begin
        logic e_stall;
        logic e_done;
        if (m_ok) begin
            e_stall = m_active ? (m_cyc < m_lat) : (mif.start && !mif.flush);
            e_done  = m_active && (m_cyc == m_lat);
            checks  = checks + 4;
            if (mif.busy !== m_active) begin
                errors = errors + 1;
                $display("FAIL model_busy t=%0t got %b want %b", $time, mif.busy, m_active);
            end
            if (mif.stall !== e_stall) begin
                errors = errors + 1;
                $display("FAIL model_stall t=%0t got %b want %b", $time, mif.stall, e_stall);
            end
            if (mif.done !== e_done) begin
                errors = errors + 1;
                $display("FAIL model_done t=%0t got %b want %b", $time, mif.done, e_done);
            end
            if (mif.result !== m_result) begin
                errors = errors + 1;
                $display("FAIL model_result t=%0t got %h want %h", $time, mif.result, m_result);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15, 0));
            4:       return -32'($urandom_range(15, 1));
            default: return $urandom;
        endcase
    endfunction

    // Starts one op in cycle 0 and waits (bounded) for done. With hold set,
    // start stays high with junk operands while busy, which must be ignored.
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want, input int lat,
                         input bit hold);
        int          done_k;
        int          stall_n;
        logic [31:0] res;
        tick();
        mif.start  = 1'b1;
        mif.Funct3 = f;
        mif.SrcA   = a;
        mif.SrcB   = b;
        mif.flush  = 1'b0;
        done_k     = -1;
        stall_n    = 0;
        res        = 'x;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                tick();
                mif.start = hold;
                if (hold) begin
                    mif.Funct3 = 3'($urandom_range(7, 0));
                    mif.SrcA   = $urandom;
                    mif.SrcB   = $urandom;
                end
            end
            #1;
            if (mif.stall === 1'b1) stall_n++;
            if (mif.done === 1'b1) begin
                done_k = k;
                res    = mif.result;
                break;
            end
        end
        mif.start = 1'b0;
        check({name, "_done_cycle"}, 32'(done_k), 32'(lat));
        check({name, "_result"}, res, want);
        check({name, "_stall_cycles"}, 32'(stall_n), 32'(lat));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          done_k;
        logic        early;
        logic [31:0] res;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        mif.start  = 1'b0;
        mif.flush  = 1'b0;
        mif.Funct3 = '0;
        mif.SrcA   = '0;
        mif.SrcB   = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_busy",   32'(mif.busy),  32'd0);
        check("reset_stall",  32'(mif.stall), 32'd0);
        check("reset_done",   32'(mif.done),  32'd0);
        check("reset_result", mif.result,     32'd0);

        do_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 1'b1);
        do_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 1'b0);
        do_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 1'b1);
        do_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT, 1'b0);
        do_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT, 1'b1);
        do_op("divu",    3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, LAT, 1'b0);
        do_op("remu",    3'd7, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, LAT, 1'b0);
        do_op("divu_z",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,   1'b1);
        do_op("rem_z",   3'd6, 32'd5,         32'd0,         32'h0000_0005, 2,   1'b0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,   1'b0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,   1'b1);
        do_op("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 1'b0);

        // Flush a DIV in cycle 10, start MUL 3x4 in cycle 11.
        tick();
        mif.start  = 1'b1;
        mif.Funct3 = 3'd4;
        mif.SrcA   = 32'd100;
        mif.SrcB   = 32'd7;
        done_k     = -1;
        early      = 1'b0;
        res        = 'x;
        for (int k = 1; k < 90; k++) begin
            tick();
            mif.start = (k == 11);
            mif.flush = (k == 10);
            if (k == 11) begin
                mif.Funct3 = 3'd0;
                mif.SrcA   = 32'd3;
                mif.SrcB   = 32'd4;
            end
            #1;
            if (k == 11) begin
                check("flush_busy_idle", 32'(mif.busy), 32'd0);
                check("flush_result_kept", mif.result, 32'hFFFF_FFEB);
            end
            if (mif.done === 1'b1) begin
                if (k <= 11) early = 1'b1;
                else begin
                    done_k = k;
                    res    = mif.result;
                    break;
                end
            end
        end
        mif.start = 1'b0;
        check("flush_no_done", 32'(early), 32'd0);
        check("after_flush_done_cycle", 32'(done_k), 32'd46);
        check("after_flush_result", res, 32'd12);

        // Reset in cycle 20 of a MUL.
        tick();
        mif.start  = 1'b1;
        mif.Funct3 = 3'd0;
        mif.SrcA   = 32'd9;
        mif.SrcB   = 32'd9;
        for (int k = 1; k <= 21; k++) begin
            tick();
            mif.start = 1'b0;
            rst       = (k == 20);
            #1;
            if (k == 21) begin
                check("rst_mid_busy",   32'(mif.busy),  32'd0);
                check("rst_mid_stall",  32'(mif.stall), 32'd0);
                check("rst_mid_result", mif.result,     32'd0);
            end
        end

        // flush together with start in IDLE.
        tick();
        mif.start = 1'b1;
        mif.flush = 1'b1;
        tick();
        mif.start = 1'b0;
        mif.flush = 1'b0;
        #1;
        check("flush_start_busy", 32'(mif.busy), 32'd0);
        tick();
        check("flush_start_busy2", 32'(mif.busy), 32'd0);

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 6000; c++) begin
            tick();
            mif.start  = ($urandom_range(2, 0) == 0);
            mif.flush  = ($urandom_range(119, 0) == 0);
            rst        = ($urandom_range(1499, 0) == 0);
            mif.Funct3 = 3'($urandom_range(7, 0));
            mif.SrcA   = pick();
            mif.SrcB   = pick();
        end
        tick();
        mif.start = 1'b0;
        mif.flush = 1'b0;
        rst       = 1'b0;
        repeat (45) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
